// File: rtl/encrypt_function_3.sv
// encrypt_function_3: two-stage valid/ready encryptor emitting {cipher[60:0], key[10:0], tag[5:0]} frames.
// Optional per-accept sequence tag in out_data[5:0] is built when ENC3_SEQ_TAG_EN is defined.
module encrypt_function_3 #(
  parameter logic [10:0] RAND_SEED = 11'h5A5
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] out_data
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [10:0] LFSR_INIT = (RAND_SEED == 11'h000) ? 11'h001 : RAND_SEED;

  typedef struct packed {
    logic [59:0] p;
    logic [10:0] k;
    logic [5:0]  tag;
  } s1_t;

  s1_t         s1_q;
  logic        s1_valid;
  logic        s2_valid;
  logic [10:0] lfsr_q;
  logic [5:0]  tag_q;
  logic        accept;
  logic        s2_load;
  logic [59:0] mask;
  logic [60:0] cipher;

  assign s2_load   = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | s2_load;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  assign mask   = {s1_q.k[4:0], s1_q.k, ~s1_q.k, s1_q.k, s1_q.k, ~s1_q.k};
  assign cipher = {s1_q.p, 1'b0} + {1'b0, mask};

  // x^11 + x^9 + 1; the pre-advance value is the key of the accepted word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      lfsr_q <= LFSR_INIT;
    else if (accept) lfsr_q <= {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
  end

`ifdef ENC3_SEQ_TAG_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      tag_q <= 6'h00;
    else if (accept) tag_q <= tag_q + 6'h01;
  end
`else
  assign tag_q = 6'h00;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_q.p   <= in_data;
        s1_q.k   <= lfsr_q;
        s1_q.tag <= tag_q;
      end
    end
  end

  // Output stage holds its frame while stalled by out_ready=0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s2_valid <= 1'b0;
      out_data <= 78'h0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) out_data <= {cipher, s1_q.k, s1_q.tag};
    end
  end

endmodule

// File: tb/tb_encrypt_function_3.sv
// Directed bench for encrypt_function_3: hand-computed anchor vectors plus a cycle model/scoreboard.
module tb_encrypt_function_3;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] out_data;

  int checks = 0;
  int errors = 0;

  encrypt_function_3 dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic        m1v, m2v;
  logic [77:0] m1f, m2f;
  logic [10:0] lfsr_m;
  logic [5:0]  tag_m;
  logic [59:0] pt_q[$];

  function automatic logic [59:0] mask_of(input logic [10:0] k);
    return {k[4:0], k, ~k, k, k, ~k};
  endfunction

  function automatic logic [77:0] frame_of(input logic [59:0] p, input logic [10:0] k, input logic [5:0] t);
    logic [60:0] y;
    y = {p, 1'b0} + {1'b0, mask_of(k)};
    return {y, k, t};
  endfunction

  function automatic logic [59:0] decrypt(input logic [60:0] y, input logic [10:0] k);
    logic [60:0] d;
    d = y - {1'b0, mask_of(k)};
    return d[60:1];
  endfunction

  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1v = 1'b0; m2v = 1'b0; m1f = '0; m2f = '0;
    lfsr_m = 11'h5A5; tag_m = 6'h00;
    pt_q.delete();
  endtask

  // Called at edge+1: drive inputs, check outputs against the model, then step to next edge+1.
  task automatic cycle(input logic iv, input logic [59:0] d, input logic ordy, output logic acc);
    logic rdy_e, s2ld;
    logic [59:0] p_exp;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    rdy_e = !m1v | !m2v | ordy;
    chk("in_ready", in_ready, rdy_e);
    chk("out_valid", out_valid, m2v);
    if (m2v) chk("out_data", out_data, m2f);
    if (m2v && ordy) begin
      p_exp = (pt_q.size() > 0) ? pt_q.pop_front() : 60'h0;
      chk("decrypt", decrypt(out_data[77:17], out_data[16:6]), p_exp);
    end
    acc  = iv & rdy_e;
    s2ld = !m2v | ordy;
    if (s2ld) begin
      m2v = m1v;
      if (m1v) m2f = m1f;
    end
    if (rdy_e) begin
      m1v = acc;
      if (acc) begin
        m1f = frame_of(d, lfsr_m, tag_m);
        pt_q.push_back(d);
        lfsr_m = {lfsr_m[9:0], lfsr_m[10] ^ lfsr_m[8]};
`ifdef ENC3_SEQ_TAG_EN
        tag_m = tag_m + 6'h01;
`endif
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [63:0] r;
    int          acc_cnt;
    Rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 78'h0);
    Rst_n = 1'b1;

    // First word p=0: key 5A5, cipher = b(5A5); second key 34A
    cycle(1'b1, 60'h0, 1'b1, acc);
    cycle(1'b1, 60'h123_4567_89AB_CDEF, 1'b1, acc);
    chk("first_cipher", out_data[77:17], 61'h2DA54B5696D2A5A);
    chk("first_key", out_data[16:6], 11'h5A5);
    cycle(1'b0, 60'h0, 1'b1, acc);
    chk("second_key", out_data[16:6], 11'h34A);
    cycle(1'b0, 60'h0, 1'b1, acc);

    // Back-to-back random traffic
    for (int i = 0; i < 100; i++) begin
      r = {$urandom(), $urandom()};
      cycle(1'b1, r[59:0], 1'b1, acc);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 60'h0, 1'b1, acc);

    // Stall: only two words fit, third must wait
    acc_cnt = 0;
    cycle(1'b1, 60'hAAA_AAAA_AAAA_AAAA, 1'b0, acc); acc_cnt += int'(acc);
    cycle(1'b1, 60'h555_5555_5555_5555, 1'b0, acc); acc_cnt += int'(acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 60'hFFF_0000_FFFF_0000, 1'b0, acc); acc_cnt += int'(acc);
    end
    chk("hold_in_ready", in_ready, 1'b0);
    chk("hold_accepts", acc_cnt, 2);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) cycle(1'b1, 60'hFFF_0000_FFFF_0000, 1'b1, acc);
    chk("hold_release_accept", acc, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 60'h0, 1'b1, acc);

    // 70 accepts exercise tag wrap (or constant zero tag)
    for (int i = 0; i < 70; i++) cycle(1'b1, 60'(i * 997), 1'b1, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 60'h0, 1'b1, acc);

    // Reset with two words in flight
    cycle(1'b1, 60'h111, 1'b0, acc);
    cycle(1'b1, 60'h222, 1'b0, acc);
    chk("inflight_valid", out_valid, 1'b1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    model_reset();
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Wrap case right after reset: key restarts at 5A5, y = b - 2
    cycle(1'b1, 60'hFFF_FFFF_FFFF_FFFF, 1'b1, acc);
    cycle(1'b0, 60'h0, 1'b0, acc);
    chk("wrap_cipher", out_data[77:17], 61'h2DA54B5696D2A58);
    chk("wrap_key", out_data[16:6], 11'h5A5);
    chk("wrap_decrypt", decrypt(out_data[77:17], out_data[16:6]), 60'hFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 60'h0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
